fwd_hazard_ctrl: RTL

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB destination info and drives EX operand mux selects plus a one-cycle stall.

module fwd_sel_unit #(
    parameter int REG_AW = 5
) (
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rw,
    input  logic              mem_mr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_rw,
    output logic [1:0]        sel
);
    // Youngest producer wins; a load in MEM has no data yet, so it is skipped.
    always_comb begin
        sel = 2'b00;
        if (use_rs && mem_rw && !mem_mr && (mem_rd != '0) && (mem_rd == rs))
            sel = 2'b10;
        else if (use_rs && wb_rw && (wb_rd != '0) && (wb_rd == rs))
            sel = 2'b01;
    end
endmodule

module fwd_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } dst_t;

    typedef struct packed {
        dst_t                           dst;
        logic [NUM_OPS-1:0][REG_AW-1:0] rs;
        logic [NUM_OPS-1:0]             use_rs;
    } ex_t;

    // Once a result reaches WB it is valid whether or not it came from a load.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } wb_t;

    ex_t  ex_q, ex_d;
    dst_t mem_q;
    wb_t  wb_q;
    logic hazard;
    logic [NUM_OPS-1:0][1:0] sel;

    assign hazard = (id_use_rs1 && (id_rs1 == ex_q.dst.rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_q.dst.rd));

    assign stall = id_valid && !flush && ex_q.dst.mem_read && ex_q.dst.reg_write &&
                   (ex_q.dst.rd != '0) && hazard;

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.dst.rd        = id_rd;
            ex_d.dst.reg_write = id_reg_write;
            ex_d.dst.mem_read  = id_mem_read;
            ex_d.rs[0]         = id_rs1;
            ex_d.rs[1]         = id_rs2;
            ex_d.use_rs        = {id_use_rs2, id_use_rs1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q.dst;
            wb_q  <= '{rd: mem_q.rd, reg_write: mem_q.reg_write};
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        fwd_sel_unit #(.REG_AW(REG_AW)) u_sel (
            .use_rs (ex_q.use_rs[g]),
            .rs     (ex_q.rs[g]),
            .mem_rd (mem_q.rd),
            .mem_rw (mem_q.reg_write),
            .mem_mr (mem_q.mem_read),
            .wb_rd  (wb_q.rd),
            .wb_rw  (wb_q.reg_write),
            .sel    (sel[g])
        );
    end

    assign fwd_a_sel = sel[0];
    assign fwd_b_sel = sel[1];
endmodule
